// File: rtl/mem1r1w_wbuf_pkg.sv
// mem1r1w_wbuf_pkg: shared entry type and masked-merge helper for the write buffer.
package mem1r1w_wbuf_pkg;
  typedef struct packed {
    logic [63:0] index;
    logic [63:0] data;
    logic [63:0] mask;
  } entry_t;

  function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] data,
                                        input logic [63:0] mask);
    return (base & ~mask) | (data & mask);
  endfunction
endpackage

// File: rtl/mem1r1w_write_buffer_if.sv
// mem1r1w_write_buffer_if: write/read request handshakes and read response of the write buffer.
interface mem1r1w_write_buffer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_index;
  logic [63:0] wr_data;
  logic [63:0] wr_mask;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_index;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;

  modport master (
    output wr_valid, wr_index, wr_data, wr_mask, rd_valid, rd_index,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );
  modport slave (
    input  wr_valid, wr_index, wr_data, wr_mask, rd_valid, rd_index,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );
endinterface

// File: rtl/mem1r1w_wbuf_fifo.sv
// mem1r1w_wbuf_fifo: DEPTH-entry write FIFO exposing every entry oldest-first with a valid vector.
module mem1r1w_wbuf_fifo
  import mem1r1w_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output entry_t           ent_o [DEPTH],
  output logic [DEPTH-1:0] valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;

  assign full_o = cnt_q == FULL;
  assign empty_o = cnt_q == '0;

  always_ff @(posedge clock)
    if (push_i) mem_q[wp_q] <= push_entry_i;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_i);
      rp_q <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

  // Position 0 is the head, so consumers see entries in age order.
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      ent_o[i] = mem_q[rp_q + AW'(i)];
      valid_o[i] = cnt_q > (AW+1)'(i);
    end
endmodule

// File: rtl/mem1r1w_write_buffer.sv
// mem1r1w_write_buffer: write buffer draining into a 1R1W memory, one write per cycle.
// Define MEM1R1W_WBUF_FWD_EN to merge buffered writes into read data instead of stalling reads.
module mem1r1w_write_buffer
  import mem1r1w_wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RAM_SIZE = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  mem1r1w_write_buffer_if.slave bus,
  output logic                  r_0_enable,
  output logic [63:0]           r_0_index,
  input  logic [63:0]           r_0_data,
  output logic                  w_0_enable,
  output logic [63:0]           w_0_index,
  output logic [63:0]           w_0_data,
  output logic [63:0]           w_0_mask,
  output logic                  err_range
);
  localparam logic [63:0] LIMIT = 64'(RAM_SIZE);
  entry_t ent [DEPTH];
  entry_t wr_ent;
  logic [DEPTH-1:0] vld, hit;
  logic full, empty, wr_fire, rd_fire, wr_oor, rd_oor;
  logic resp_q, oor_q, err_q;
  logic [63:0] resp_data;

  assign wr_ent = '{index: bus.wr_index, data: bus.wr_data, mask: bus.wr_mask};
  assign wr_oor = bus.wr_index >= LIMIT;
  assign rd_oor = bus.rd_index >= LIMIT;
  assign wr_fire = bus.wr_valid & ~full;
  assign rd_fire = bus.rd_valid & bus.rd_ready;
  assign bus.wr_ready = ~full;

  // Out-of-range writes complete the handshake but never reach the FIFO.
  mem1r1w_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (wr_fire & ~wr_oor),
    .push_entry_i (wr_ent),
    .pop_i        (~empty),
    .full_o       (full),
    .empty_o      (empty),
    .ent_o        (ent),
    .valid_o      (vld)
  );

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = vld[i] && ent[i].index == bus.rd_index;
  end

`ifdef MEM1R1W_WBUF_FWD_EN
  logic [63:0] ovr_data_d, ovr_mask_d, ovr_data_q, ovr_mask_q;
  // Fold matching entries oldest to youngest into one overlay applied to next cycle's memory data.
  always_comb begin
    ovr_data_d = '0;
    ovr_mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ovr_data_d = hit[i] ? merge(ovr_data_d, ent[i].data, ent[i].mask) : ovr_data_d;
      ovr_mask_d = hit[i] ? ovr_mask_d | ent[i].mask : ovr_mask_d;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ovr_data_q <= '0;
      ovr_mask_q <= '0;
    end else begin
      ovr_data_q <= ovr_data_d;
      ovr_mask_q <= ovr_mask_d;
    end
  assign bus.rd_ready = ~reset;
  assign resp_data = merge(r_0_data, ovr_data_q, ovr_mask_q);
`else
  assign bus.rd_ready = ~|hit;
  assign resp_data = r_0_data;
`endif

  assign r_0_enable = rd_fire & ~rd_oor;
  assign r_0_index = r_0_enable ? bus.rd_index : '0;
  assign w_0_enable = ~empty;
  assign w_0_index = empty ? '0 : ent[0].index;
  assign w_0_data = empty ? '0 : ent[0].data;
  assign w_0_mask = empty ? '0 : ent[0].mask;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      resp_q <= 1'b0;
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      resp_q <= rd_fire;
      oor_q <= rd_oor;
      err_q <= err_q | (wr_fire & wr_oor) | (rd_fire & rd_oor);
    end

  assign bus.rd_resp_valid = resp_q;
  assign bus.rd_resp_data = resp_q && !oor_q ? resp_data : '0;
  assign err_range = err_q;
endmodule

// File: tb/tb_mem1r1w_write_buffer.sv
// tb_mem1r1w_write_buffer: random and directed stimulus; a monitor checks drains and read responses
// against an architectural memory image in which every accepted write lands in acceptance order.
module tb_mem1r1w_write_buffer;
  import mem1r1w_wbuf_pkg::*;
  localparam int DEPTH = 4;
  localparam int RAM = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem1r1w_write_buffer_if bus();
  logic        r_0_enable, w_0_enable, err_range;
  logic [63:0] r_0_index, w_0_index, w_0_data, w_0_mask;
  logic [63:0] r_0_data = '0;

  mem1r1w_write_buffer #(.DEPTH(DEPTH), .RAM_SIZE(RAM)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .r_0_enable (r_0_enable),
    .r_0_index  (r_0_index),
    .r_0_data   (r_0_data),
    .w_0_enable (w_0_enable),
    .w_0_index  (w_0_index),
    .w_0_data   (w_0_data),
    .w_0_mask   (w_0_mask),
    .err_range  (err_range)
  );

  // Downstream memory: read data one cycle after enable, read sees the old contents.
  logic [63:0] mem [RAM] = '{default: '0};
  always @(posedge clock) begin
    if (r_0_enable) r_0_data <= mem[r_0_index[9:0]];
    if (w_0_enable) mem[w_0_index[9:0]] <= (mem[w_0_index[9:0]] & ~w_0_mask) | (w_0_data & w_0_mask);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } rexp_t;
  rexp_t       rq[$];
  entry_t      dq[$];
  logic [63:0] arch [RAM] = '{default: '0};
  bit          err_exp = 0;
  int          cyc = 0;

  initial forever begin
    bit          ra, exp_rdy;
    entry_t      e;
    rexp_t       r;
    @(negedge clock);
    cyc++;
    if (reset) begin
      rq.delete();
      dq.delete();
      err_exp = 0;
      for (int i = 0; i < RAM; i++) arch[i] = mem[i];
      continue;
    end
    chk("err_range", err_range, err_exp);
    chk("wr_ready", bus.wr_ready, dq.size() < DEPTH);
    exp_rdy = 1;
`ifndef MEM1R1W_WBUF_FWD_EN
    foreach (dq[k]) if (dq[k].index == bus.rd_index) exp_rdy = 0;
`endif
    chk("rd_ready", bus.rd_ready, exp_rdy);
    if (dq.size() == 0) chk("w_0_idle", w_0_enable, 0);
    else begin
      e = dq.pop_front();
      chk("w_0_enable", w_0_enable, 1);
      chk("w_0_index", w_0_index, e.index);
      chk("w_0_data", w_0_data, e.data);
      chk("w_0_mask", w_0_mask, e.mask);
    end
    if (rq.size() == 0) chk("resp_spurious", bus.rd_resp_valid, 0);
    else if (bus.rd_resp_valid || rq[0].cyc < cyc) begin
      r = rq.pop_front();
      chk("resp_valid", bus.rd_resp_valid, 1);
      chk("resp_latency", 64'(cyc), 64'(r.cyc + 1));
      chk("resp_data", bus.rd_resp_data, r.data);
    end
    ra = bus.rd_valid && bus.rd_ready;
    chk("r_0_enable", r_0_enable, ra && bus.rd_index < RAM);
    if (r_0_enable) chk("r_0_index", r_0_index, bus.rd_index);
    if (ra) begin
      rq.push_back('{cyc: cyc, data: bus.rd_index < RAM ? arch[bus.rd_index[9:0]] : 64'h0});
      if (bus.rd_index >= RAM) err_exp = 1;
    end
    if (bus.wr_valid && bus.wr_ready) begin
      if (bus.wr_index < RAM) begin
        dq.push_back('{index: bus.wr_index, data: bus.wr_data, mask: bus.wr_mask});
        arch[bus.wr_index[9:0]] = (arch[bus.wr_index[9:0]] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
      end else err_exp = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold each request until accepted; both may be presented in the same cycle.
  task automatic issue(input bit dw, input logic [63:0] wi, input logic [63:0] wd, input logic [63:0] wm,
                       input bit dr, input logic [63:0] ri);
    bit wa, ra;
    bus.wr_valid = dw;
    bus.wr_index = wi;
    bus.wr_data = wd;
    bus.wr_mask = wm;
    bus.rd_valid = dr;
    bus.rd_index = ri;
    for (int k = 0; k < 50 && (bus.wr_valid || bus.rd_valid); k++) begin
      @(negedge clock);
      wa = bus.wr_valid && bus.wr_ready;
      ra = bus.rd_valid && bus.rd_ready;
      @(posedge clock);
      #1;
      if (wa) bus.wr_valid = 0;
      if (ra) bus.rd_valid = 0;
    end
    chk("accept_timeout", {62'b0, bus.wr_valid, bus.rd_valid}, 0);
    bus.wr_valid = 0;
    bus.rd_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] wi, wd, wm, ri;
    bit dw, dr;
    bus.wr_valid = 0;
    bus.wr_index = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.rd_valid = 0;
    bus.rd_index = '0;
    repeat (2) @(negedge clock);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_w_0_enable", w_0_enable, 0);
    chk("rst_r_0_enable", r_0_enable, 0);
    chk("rst_resp_valid", bus.rd_resp_valid, 0);
    chk("rst_resp_data", bus.rd_resp_data, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_w_0_index", w_0_index, 0);
    chk("rst_w_0_data", w_0_data, 0);
    chk("rst_w_0_mask", w_0_mask, 0);
    chk("rst_r_0_index", r_0_index, 0);
    @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < 4; i++) issue(1, 64'(i), 64'hA0 + 64'(i), '1, 0, 0);
    idle(3);
    for (int i = 0; i < 6; i++) issue(1, 64'(8 + i), 64'hB0 + 64'(i), '1, 0, 0);
    idle(3);
    issue(1, 7, 64'h55, '1, 0, 0);
    idle(3);
    issue(1, 5, 64'hFFFF, 64'h00FF, 0, 0);
    issue(1, 5, 64'h1200, 64'hFF00, 1, 5);
    issue(0, 0, 0, 0, 1, 5);
    idle(3);
    issue(1, 7, 64'hDEAD, '1, 1, 7);
    issue(0, 0, 0, 0, 1, 7);
    idle(3);
    for (int i = 0; i < 8; i++) issue(0, 0, 0, 0, 1, 64'(i));
    idle(2);
    for (int n = 0; n < 300; n++) begin
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      wi = 64'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      wm = $urandom_range(0, 3) == 0 ? '1 : {$urandom, $urandom};
      ri = 64'($urandom_range(0, 7));
      if (dw || dr) issue(dw, wi, wd, wm, dr, ri);
      else idle(1);
    end
    idle(3);
    issue(1, 1024, 64'h1, '1, 1, 2000);
    idle(3);
    issue(1, 3, 64'h77, '1, 1, 3);
    idle(3);
    issue(1, 1, 64'h111, '1, 0, 0);
    issue(1, 2, 64'h222, '1, 0, 0);
    issue(1, 3, 64'h333, '1, 1, 3);
    reset = 1;
    @(negedge clock);
    chk("midrst_w_0_enable", w_0_enable, 0);
    chk("midrst_resp_valid", bus.rd_resp_valid, 0);
    chk("midrst_err_range", err_range, 0);
    @(posedge clock);
    #1 reset = 0;
    idle(5);
    issue(0, 0, 0, 0, 1, 3);
    issue(0, 0, 0, 0, 1, 5);
    idle(3);
    chk("drain_queue_empty", 64'(dq.size()), 0);
    chk("resp_queue_empty", 64'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem1r1w_write_buffer.md
MEM1R1W_WRITE_BUFFER -- requirements
Module: mem1r1w_write_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of buffered write entries (power of two, 2..16).
REQ-002 SHALL provide parameter RAM_SIZE, default 1024, number of 64-bit words in the downstream Mem1R1WHelper.
REQ-003 clock  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wr_valid/wr_ready  in/out  1/1  write request handshake.
REQ-006 wr_index, wr_data, wr_mask  in  64 each  word index, data, per-bit write mask.
REQ-007 rd_valid/rd_ready  in/out  1/1  read request handshake.
REQ-008 rd_index  in  64  read word index.
REQ-009 rd_resp_valid, rd_resp_data  out  1, 64  read response.
REQ-010 r_0_enable, r_0_index  out  1, 64  to memory read port.
REQ-011 r_0_data  in  64  memory read data, valid cycle after r_0_enable.
REQ-012 w_0_enable, w_0_index, w_0_data, w_0_mask  out  1, 64, 64, 64  to memory write port.
REQ-013 err_range  out  1  sticky: an out-of-range index was received.

Function
REQ-014 Write accepted when wr_valid & wr_ready; wr_ready = !full (no same-cycle pass-through when full, even if draining).
REQ-015 Accepted writes SHALL enqueue in order into a DEPTH-entry FIFO {index, data, mask}.
REQ-016 When FIFO non-empty, head SHALL drive w_0_* with w_0_enable=1 and be dequeued that cycle; one drain per cycle, strict order.
REQ-017 Enqueue and drain in same cycle SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-018 Write with wr_index >= RAM_SIZE SHALL be accepted, discarded (not enqueued) and set err_range.
REQ-019 Read accepted when rd_valid & rd_ready; in cycle t r_0_enable=1, r_0_index=rd_index combinationally; otherwise r_0_enable=0.
REQ-020 Response SHALL appear exactly at t+1: rd_resp_valid=1 for one cycle.
REQ-021 rd_resp_data = r_0_data merged, oldest to youngest, with every FIFO entry valid at cycle t (including the entry draining at t) whose index equals rd_index: d = (d & ~mask) | (data & mask).
REQ-022 A write accepted in cycle t SHALL be ordered after a read accepted in cycle t (not forwarded).
REQ-023 Read with rd_index >= RAM_SIZE SHALL respond at t+1 with data 0, no memory access, and set err_range.
REQ-024 Back-to-back reads every cycle SHALL be supported at full throughput.

Reset
REQ-025 On reset: FIFO empty, wr_ready=1, w_0_enable=0, r_0_enable=0, rd_resp_valid=0, err_range=0, data outputs 0.
REQ-026 Reset mid-operation SHALL discard all buffered writes and any in-flight read response.

Configuration
REQ-027 Macro MEM1R1W_WBUF_FWD_EN defined: forwarding per REQ-021, rd_ready=1 whenever not in reset.
REQ-028 Macro undefined: no merge; rd_ready=0 while any valid entry (incl. draining) matches rd_index; response = r_0_data.

Structure
REQ-029 Package mem1r1w_wbuf_pkg SHALL hold the entry struct typedef (index, data, mask) and the merge function.
REQ-030 FIFO storage/pointers SHALL be sub-module mem1r1w_wbuf_fifo exposing all entries plus valid vector for forwarding.

Verification
REQ-031 Reset, then 4 writes idx 0..3 data 0xA0..0xA3 mask all-ones -> w_0 pulses cycles 1..4 in order, wr_ready stays 1.
REQ-032 Hold draining off by filling 4 writes same cycle-stream with continuous wr_valid, DEPTH=4 -> 5th write stalls only when full; occupancy never exceeds 4.
REQ-033 Memory idx 5 = 0x0; buffered writes idx 5 data 0xFFFF mask 0x00FF then 0x1200 mask 0xFF00; read idx 5 same cycle -> FWD_EN: resp 0x12FF at t+1; without: rd_ready=0 until both drained, then resp 0x12FF.
REQ-034 Read idx 7 and write idx 7 accepted same cycle, memory 0x55 -> resp 0x55, later read -> new data.
REQ-035 Write idx 1024, read idx 2000 -> nothing enqueued, resp 0 at t+1, err_range=1 until reset.
REQ-036 Assert reset with 3 entries buffered and read in flight -> no w_0_enable, no rd_resp_valid after release.
